// File: rtl/medidor_pkg.sv
// Shared definitions for the frequency meter: FSM state encoding and the
// default counter width.
package medidor_pkg;

   localparam int CNT_W_DEF = 20;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_COUNT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/sync_borda.sv
// Multi-flop synchronizer for an asynchronous input followed by a rising-edge
// detector; every flop clears on the asynchronous active-low reset.
module sync_borda #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_rise
);

   logic [STAGES-1:0] r_sync;
   logic              r_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_async};
         r_prev <= r_sync[STAGES-1];
      end
   end

   assign o_rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/medidor_freq.sv
// Frequency meter: counts synchronized rising edges of sig_in between two
// tick pulses and hands the saturating result out over valid/ready.
//
// Handshake: valid rises one cycle after the closing tick and stays high,
// with count_out/overflow frozen, until a cycle where valid and ready are
// both high; valid drops on the next cycle. ready may be high before valid.
module medidor_freq
   import medidor_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic             f_in,
   input  logic             rst_n,
   input  logic             sig_in,
   input  logic             tick,
   input  logic             start,
   output logic             busy,
   output logic [CNT_W-1:0] count_out,
   output logic             overflow,
   output logic             valid,
   input  logic             ready,
   output logic [1:0]       o_dbg_state
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]       r_state;
   logic [1:0]       w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             r_ovf;
   logic [CNT_W-1:0] r_count_out;
   logic             r_ovf_out;
   logic             r_valid;
   logic             w_edge;
   logic             w_at_max;

   sync_borda #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .i_clk   (f_in),
      .i_rst_n (rst_n),
      .i_async (sig_in),
      .o_rise  (w_edge)
   );

   always_ff @(posedge f_in or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (start)           w_next = ST_ARMED;
         ST_ARMED: if (tick)            w_next = ST_COUNT;
         ST_COUNT: if (tick)            w_next = ST_DONE;
         ST_DONE:  if (r_valid & ready) w_next = ST_IDLE;
         default:                       w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy        = (r_state != ST_IDLE);
      o_dbg_state = r_state;
      count_out   = r_count_out;
      overflow    = r_ovf_out;
      valid       = r_valid;
   end

   // Saturating increment: at full scale the count holds and the lost edge
   // is remembered in the overflow flag.
   assign w_at_max  = (r_cnt == CNT_MAX);
   assign w_cnt_inc = w_at_max ? r_cnt : r_cnt + CNT_W'(1);

   always_ff @(posedge f_in or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
         r_count_out <= '0;
         r_ovf_out   <= 1'b0;
         r_valid     <= 1'b0;
      end else begin
         case (r_state)
            ST_ARMED: begin
               if (tick) begin
                  r_cnt <= '0;
                  r_ovf <= 1'b0;
               end
            end
            ST_COUNT: begin
               if (w_edge) begin
                  r_cnt <= w_cnt_inc;
                  if (w_at_max) r_ovf <= 1'b1;
               end
               // The edge coinciding with the closing tick still belongs to the window.
               if (tick) begin
                  r_count_out <= w_edge ? w_cnt_inc : r_cnt;
                  r_ovf_out   <= r_ovf | (w_edge & w_at_max);
                  r_valid     <= 1'b1;
               end
            end
            ST_DONE: begin
               if (ready) r_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_medidor_freq.sv
// Directed bench for medidor_freq: a 20-bit and an 8-bit instance share all
// inputs so the saturation case is seen side by side with the wide counter.
module tb_medidor_freq;
   import medidor_pkg::*;

   // Cycles from driving sig_in high to the synchronized edge being visible.
   localparam int EDGE_LAT = 2;

   logic        f_in;
   logic        rst_n;
   logic        sig_in;
   logic        tick;
   logic        start;
   logic        ready;
   logic        busy;
   logic [19:0] count_out;
   logic        overflow;
   logic        valid;
   logic [1:0]  dbg_state;
   logic        busy8;
   logic [7:0]  count8;
   logic        overflow8;
   logic        valid8;
   logic [1:0]  dbg_state8;

   int n_tests;
   int n_fail;
   logic [31:0] exp_q[$];

   medidor_freq dut (
      .f_in        (f_in),
      .rst_n       (rst_n),
      .sig_in      (sig_in),
      .tick        (tick),
      .start       (start),
      .busy        (busy),
      .count_out   (count_out),
      .overflow    (overflow),
      .valid       (valid),
      .ready       (ready),
      .o_dbg_state (dbg_state)
   );

   medidor_freq #(
      .CNT_W (8)
   ) dut8 (
      .f_in        (f_in),
      .rst_n       (rst_n),
      .sig_in      (sig_in),
      .tick        (tick),
      .start       (start),
      .busy        (busy8),
      .count_out   (count8),
      .overflow    (overflow8),
      .valid       (valid8),
      .ready       (ready),
      .o_dbg_state (dbg_state8)
   );

   // Clock / reset
   initial begin
      f_in = 1'b0;
      forever #10 f_in = ~f_in;
   end

   task automatic step();
      @(posedge f_in);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   // Square wave with period p rising at indices k = ph (mod p); p = 0 is constant high.
   function automatic logic pat(input int k, input int p, input int ph);
      int m;
      if (p == 0) return 1'b1;
      m = (k - ph) % p;
      if (m < 0) m += p;
      return (m < p / 2);
   endfunction

   // One full measurement: start, window of len cycles between ticks, result
   // held for 'hold' cycles with ready low, then a single ready cycle.
   task automatic measure(input string tag, input int len, input int p, input int ph,
                          input int hold, input bit start_mid, input int exp_n);
      logic [31:0] e20;
      logic [31:0] e8;
      logic        o8;
      exp_q.push_back(exp_n);
      ready = 1'b0;
      for (int c = -4; c <= len; c++) begin
         start  = (c == -4) || (start_mid && c == len / 2 && c > 0 && c < len);
         tick   = (c == 0) || (c == len);
         sig_in = pat(c + EDGE_LAT, p, ph);
         step();
         if (c == -4)      check({tag, "_busy_after_start"}, busy, 1);
         if (c == len - 1) check({tag, "_valid_early"}, valid, 0);
      end
      start  = 1'b0;
      tick   = 1'b0;
      sig_in = 1'b0;
      e20 = exp_q.pop_front();
      e8  = (e20 > 255) ? 32'd255 : e20;
      o8  = (e20 > 255);
      check({tag, "_valid"}, valid, 1);
      check({tag, "_count"}, count_out, e20);
      check({tag, "_ovf"}, overflow, 0);
      check({tag, "_count8"}, count8, e8);
      check({tag, "_ovf8"}, overflow8, o8);
      for (int i = 0; i < hold; i++) begin
         step();
         check({tag, "_hold_valid"}, valid, 1);
         check({tag, "_hold_count"}, count_out, e20);
      end
      ready = 1'b1;
      step();
      ready = 1'b0;
      check({tag, "_valid_drop"}, valid, 0);
      check({tag, "_idle_state"}, dbg_state, ST_IDLE);
      check({tag, "_idle_busy"}, busy, 0);
      check({tag, "_count_kept"}, count_out, e20);
      if (start_mid) begin
         step();
         step();
         check({tag, "_start_not_queued"}, busy, 0);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      sig_in  = 1'b0;
      tick    = 1'b0;
      start   = 1'b0;
      ready   = 1'b0;
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_valid", valid, 0);
      check("rst_count", count_out, 0);
      check("rst_ovf", overflow, 0);
      check("rst_state", dbg_state, ST_IDLE);
      rst_n = 1'b1;
      repeat (2) step();
      check("post_rst_state", dbg_state, ST_IDLE);

      measure("nominal", 1000, 10, 5, 2, 1'b0, 100);
      measure("sat", 1200, 4, 1, 2, 1'b0, 300);
      measure("after_sat", 80, 4, 1, 2, 1'b0, 20);
      measure("hold50", 100, 10, 5, 50, 1'b1, 10);
      measure("bounds", 40, 10, 0, 2, 1'b0, 4);

      // Asynchronous reset in the middle of a window
      start = 1'b1;
      step();
      start = 1'b0;
      tick  = 1'b1;
      step();
      tick  = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         sig_in = pat(c + EDGE_LAT, 10, 5);
         step();
      end
      check("abort_in_count", dbg_state, ST_COUNT);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_valid", valid, 0);
      check("abort_count", count_out, 0);
      check("abort_ovf", overflow, 0);
      check("abort_state", dbg_state, ST_IDLE);
      sig_in = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      repeat (3) step();
      check("abort_stays_idle", busy, 0);
      measure("after_rst", 70, 10, 5, 2, 1'b0, 7);

      // sig_in already high when reset releases, never toggling afterwards
      rst_n  = 1'b0;
      sig_in = 1'b1;
      step();
      rst_n = 1'b1;
      repeat (5) step();
      measure("sig_hi", 50, 0, 0, 2, 1'b0, 0);

      measure("tick_tick_edge", 1, 4, 1, 2, 1'b0, 1);
      measure("tick_tick_open", 1, 4, 0, 2, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
